// File: rtl/ssd_count_ctrl.sv
// Control stage for the two-digit SSD path: debounced run/clear buttons, a direction
// switch, an 8-bit up/down hex counter and the free-running digit-multiplex clock.
module ssd_count_ctrl #(
  parameter int MUX_DIV    = 50000,
  parameter int TICK_DIV   = 10000000,
  parameter int DEB_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_run,
  input  logic       btn_clr,
  input  logic       sw_dir,
  output logic       mux_clk,
  output logic [7:0] data,
  output logic       running
);

  localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int MW = (MUX_DIV > 1) ? $clog2(MUX_DIV) : 1;
  localparam int TW = $clog2(TICK_DIV);

  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
  localparam logic [MW-1:0] MUX_LAST  = MW'(MUX_DIV - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  // Bit 0 = btn_run, bit 1 = btn_clr, bit 2 = sw_dir.
  logic [2:0]    r_sync1;
  logic [2:0]    r_sync2;
  logic [1:0]    r_deb;
  logic [1:0]    r_deb_q;
  logic [1:0]    r_press;
  logic [DW-1:0] r_dc [2];
  logic [MW-1:0] r_mux_cnt;
  logic [TW-1:0] r_tick;
  logic          w_step;

  // NOTE: every sequential block uses non-blocking assignments so that all
  // registers sample pre-edge values and the two synchronizer stages stay distinct.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= {sw_dir, btn_clr, btn_run};
      r_sync2 <= r_sync1;
    end
  end

  // A level is accepted only after DEB_CYCLES consecutive cycles of disagreement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_deb   <= '0;
      r_deb_q <= '0;
      r_press <= '0;
      for (int i = 0; i < 2; i++) r_dc[i] <= '0;
    end else begin
      r_deb_q <= r_deb;
      r_press <= r_deb & ~r_deb_q;
      for (int i = 0; i < 2; i++) begin
        if (r_sync2[i] == r_deb[i]) begin
          r_dc[i] <= '0;
        end else if (r_dc[i] == DEB_LAST) begin
          r_deb[i] <= r_sync2[i];
          r_dc[i]  <= '0;
        end else begin
          r_dc[i] <= r_dc[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mux_cnt <= '0;
      mux_clk   <= 1'b0;
    end else if (r_mux_cnt == MUX_LAST) begin
      r_mux_cnt <= '0;
      mux_clk   <= ~mux_clk;
    end else begin
      r_mux_cnt <= r_mux_cnt + 1'b1;
    end
  end

  assign w_step = running && (r_tick == TICK_LAST);

  // Clear overrides a coincident step; a run toggle never suppresses one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tick  <= '0;
      data    <= 8'h00;
      running <= 1'b1;
    end else begin
      if (r_press[1]) begin
        r_tick <= '0;
        data   <= 8'h00;
      end else begin
        if (running) r_tick <= w_step ? '0 : r_tick + 1'b1;
        if (w_step)  data   <= r_sync2[2] ? data - 8'd1 : data + 8'd1;
      end
      if (r_press[0]) running <= ~running;
    end
  end

endmodule
